// File: rtl/serializador_pacote_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serializador_pacote_pkg
// Description : Shared widths, frame length, FSM state encoding and the
//               serial-line level decode for the packet serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package serializador_pacote_pkg;

  localparam int LARGURA_DADOS    = 8;
  localparam int LARGURA_ENDERECO = 3;
  localparam int LARGURA_PACOTE   = LARGURA_ENDERECO + LARGURA_DADOS;

  // start + packet bits + parity + stop
  localparam int BITS_QUADRO      = LARGURA_PACOTE + 3;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    PARADA   = 3'd4
  } estado_t;

  // Line level driven while in a given state.
  function automatic logic nivel_tx(input estado_t estado,
                                    input logic    lsb,
                                    input logic    paridade);
    logic nivel;
    nivel = 1'b1;
    case (estado)
      INICIO:   nivel = 1'b0;
      DADOS:    nivel = lsb;
      PARIDADE: nivel = paridade;
      default:  nivel = 1'b1;
    endcase
    return nivel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serializador_pacote_divisor_bit.sv
`default_nettype none
// ============================================================================
// Module      : divisor_bit
// Description : Bit-period counter. Counts 0..DIV_BIT-1 while enabled and
//               flags the last cycle of each period with fim_bit_o.
// Revision    : 1.0 - initial release
// ============================================================================
module divisor_bit #(
  parameter int DIV_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic limpar_i,
  input  logic habilita_i,
  output logic fim_bit_o
);

  localparam int            c_LARGURA = (DIV_BIT > 1) ? $clog2(DIV_BIT) : 1;
  localparam logic [c_LARGURA-1:0] c_LIMITE = c_LARGURA'(DIV_BIT - 1);

  logic [c_LARGURA-1:0] cnt_q;
  logic [c_LARGURA-1:0] cnt_d;

  assign fim_bit_o = habilita_i && (cnt_q == c_LIMITE);

  // Next count: wrap at the end of each period, hold when disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (limpar_i || fim_bit_o) begin
      cnt_d = '0;
    end else if (habilita_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serializador_pacote.sv
`default_nettype none
// ============================================================================
// Module      : serializador_pacote
// Description : Accepts an {endereco,dados} packet over valid/ready and sends
//               it serially: start, packet LSB first, even parity, stop.
//               Each bit lasts DIV_BIT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module serializador_pacote #(
  parameter int LARGURA_PACOTE = serializador_pacote_pkg::LARGURA_PACOTE,
  parameter int DIV_BIT        = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LARGURA_PACOTE-1:0] pacote,
  input  logic                      pacote_valido,
  output logic                      pronto,
  output logic                      tx,
  output logic                      ocupado,
  output logic                      fim_tx
);

  import serializador_pacote_pkg::*;

  localparam logic [3:0] c_ULTIMO_BIT = 4'(LARGURA_PACOTE - 1);

  estado_t                   estado_q, estado_d;
  logic [LARGURA_PACOTE-1:0] desloc_q, desloc_d;
  logic [3:0]                nbit_q,   nbit_d;
  logic                      par_q,    par_d;
  logic                      tx_q,     tx_d;
  logic                      fim_q,    fim_d;

  logic                      w_fim_bit;
  logic                      w_ocioso;

  assign w_ocioso = (estado_q == OCIOSO);
  assign pronto   = w_ocioso;
  assign ocupado  = ~w_ocioso;
  assign tx       = tx_q;
  assign fim_tx   = fim_q;

  // The divider runs only while a frame is in flight and restarts on accept.
  divisor_bit #(
    .DIV_BIT (DIV_BIT)
  ) u_divisor_bit (
    .clk        (clk),
    .rst_n      (rst_n),
    .limpar_i   (w_ocioso),
    .habilita_i (~w_ocioso),
    .fim_bit_o  (w_fim_bit)
  );

  // Next-state, shift register, bit counter and registered-output decode.
  always_comb begin
    estado_d = estado_q;
    desloc_d = desloc_q;
    nbit_d   = nbit_q;
    par_d    = par_q;
    fim_d    = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (pacote_valido) begin
          desloc_d = pacote;
          par_d    = ^pacote;
          nbit_d   = 4'd0;
          estado_d = INICIO;
        end
      end
      INICIO: begin
        if (w_fim_bit) estado_d = DADOS;
      end
      DADOS: begin
        if (w_fim_bit) begin
          desloc_d = desloc_q >> 1;
          if (nbit_q == c_ULTIMO_BIT) begin
            nbit_d   = 4'd0;
            estado_d = PARIDADE;
          end else begin
            nbit_d   = nbit_q + 4'd1;
          end
        end
      end
      PARIDADE: begin
        if (w_fim_bit) estado_d = PARADA;
      end
      PARADA: begin
        if (w_fim_bit) begin
          estado_d = OCIOSO;
          fim_d    = 1'b1;
        end
      end
      default: estado_d = OCIOSO;
    endcase

    // tx is registered, so it is decoded from the state being entered.
    tx_d = nivel_tx(estado_d, desloc_d[0], par_d);
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      desloc_q <= '0;
      nbit_q   <= 4'd0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      fim_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      desloc_q <= desloc_d;
      nbit_q   <= nbit_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      fim_q    <= fim_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serializador_pacote.sv
`default_nettype none
// ============================================================================
// Module      : tb_serializador_pacote
// Description : Directed self-checking bench for serializador_pacote with
//               DIV_BIT=4 and DIV_BIT=1 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serializador_pacote;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] pacote;
  logic        valido0, valido1;
  logic        pronto0, tx0, ocupado0, fim0;
  logic        pronto1, tx1, ocupado1, fim1;
  bit          sel_dut;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serializador_pacote #(.LARGURA_PACOTE(11), .DIV_BIT(4)) u_dut4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .pacote        (pacote),
    .pacote_valido (valido0),
    .pronto        (pronto0),
    .tx            (tx0),
    .ocupado       (ocupado0),
    .fim_tx        (fim0)
  );

  serializador_pacote #(.LARGURA_PACOTE(11), .DIV_BIT(1)) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .pacote        (pacote),
    .pacote_valido (valido1),
    .pronto        (pronto1),
    .tx            (tx1),
    .ocupado       (ocupado1),
    .fim_tx        (fim1)
  );

  wire o_tx  = sel_dut ? tx1      : tx0;
  wire o_pr  = sel_dut ? pronto1  : pronto0;
  wire o_oc  = sel_dut ? ocupado1 : ocupado0;
  wire o_fim = sel_dut ? fim1     : fim0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_valido(input logic v);
    if (sel_dut) valido1 = v;
    else         valido0 = v;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".tx"},      32'(o_tx),  32'd1);
    check({tag, ".pronto"},  32'(o_pr),  32'd1);
    check({tag, ".ocupado"}, 32'(o_oc),  32'd0);
    check({tag, ".fim_tx"},  32'(o_fim), 32'd0);
  endtask

  // Offers p at the current cycle and checks the whole frame plus the fim_tx
  // cycle. par_esp is the hand-computed even-parity bit for p.
  task automatic enviar(input string tag, input logic [10:0] p, input logic par_esp,
                        input bit manter, input bit perturbar);
    int          div;
    logic [13:0] quadro;
    div    = sel_dut ? 1 : 4;
    quadro = {1'b1, par_esp, p, 1'b0};
    pacote = p;
    set_valido(1'b1);
    tick();
    for (int c = 0; c < 14 * div; c++) begin
      if (!manter) set_valido(1'b0);
      if (perturbar) begin
        pacote = 11'($urandom);
        set_valido((c < 14 * div - 4) ? c[0] : 1'b0);
      end
      check($sformatf("%s.tx[%0d]", tag, c), 32'(o_tx), 32'(quadro[c / div]));
      check($sformatf("%s.ocupado[%0d]", tag, c), 32'(o_oc), 32'd1);
      check($sformatf("%s.pronto[%0d]", tag, c), 32'(o_pr), 32'd0);
      check($sformatf("%s.fim[%0d]", tag, c), 32'(o_fim), 32'd0);
      tick();
    end
    check({tag, ".fim_tx_end"}, 32'(o_fim), 32'd1);
    check({tag, ".pronto_end"}, 32'(o_pr),  32'd1);
    check({tag, ".tx_end"},     32'(o_tx),  32'd1);
    check({tag, ".ocupado_end"},32'(o_oc),  32'd0);
  endtask

  initial begin
    sel_dut = 1'b0;
    rst_n   = 1'b0;
    pacote  = 11'h155;
    valido0 = 1'b1;
    valido1 = 1'b1;

    // Reset held 3 cycles with valid asserted: no accept.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("reset%0d", i));
      check($sformatf("reset%0d.pronto1", i), 32'(pronto1), 32'd1);
    end
    rst_n   = 1'b1;
    valido0 = 1'b0;
    valido1 = 1'b0;
    tick();
    check_idle("pos_reset");

    // Single frames and parity corners (DIV_BIT=4).
    enviar("f2AA", 11'h2AA, 1'b1, 1'b0, 1'b0);
    tick();
    check_idle("gap_2AA");
    enviar("f000", 11'h000, 1'b0, 1'b0, 1'b0);
    enviar("f7FF", 11'h7FF, 1'b1, 1'b0, 1'b0);
    enviar("f001", 11'h001, 1'b1, 1'b0, 1'b0);

    // Back-to-back with valid held: second accept happens in the fim_tx cycle.
    enviar("b0FF", 11'h0FF, 1'b0, 1'b1, 1'b0);
    enviar("b5C3", 11'h5C3, 1'b0, 1'b0, 1'b0);
    tick();
    check_idle("gap_b2b");

    // Busy-time input changes are ignored; no extra frame afterwards.
    enviar("p13A", 11'h13A, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_idle($sformatf("pos_perturb%0d", i));
    end

    // Mid-frame reset during DADOS bit 5.
    pacote  = 11'h2AA;
    valido0 = 1'b1;
    tick();
    valido0 = 1'b0;
    for (int c = 0; c < 25; c++) tick();
    check("mid.ocupado_before", 32'(ocupado0), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle("mid_reset");
    for (int i = 0; i < 60; i++) begin
      tick();
      check_idle($sformatf("pos_mid%0d", i));
    end
    enviar("r13A", 11'h13A, 1'b1, 1'b0, 1'b0);

    // DIV_BIT=1: one cycle per bit, 14-cycle frame.
    sel_dut = 1'b1;
    tick();
    check_idle("div1_idle");
    enviar("d2AA", 11'h2AA, 1'b1, 1'b0, 1'b0);
    enviar("d001", 11'h001, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
